// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch-side master for a read-only instruction memory. Holds the PC,
//   drives it on the memory address bus, waits WAIT_CYCLES clocks for the
//   read data, then presents the word to decode over a valid/ready handshake.
//   Redirects reload the PC; an out-of-range or misaligned PC stops fetch
//   and raises a sticky fault until the next redirect or reset.
//
// Ports
//   CLK            in   1   rising-edge clock
//   Reset_L        in   1   asynchronous active-low reset
//   imem_addr      out  64  instruction memory address (the PC register)
//   imem_data      in   32  instruction memory read data
//   inst_valid     out  1   inst/inst_pc hold a fetched instruction
//   inst_ready     in   1   decode accepts inst this cycle
//   inst           out  32  fetched instruction word
//   inst_pc        out  64  byte address of inst
//   redirect_valid in   1   load redirect_pc as the next fetch PC
//   redirect_pc    in   64  redirect target
//   fault          out  1   sticky: fetch stopped on a bad PC
//
// state | meaning
// FETCH | address on bus, counting read latency (bad PC -> HALT)
// VALID | word held for decode until inst_ready
// HALT  | bad PC seen, fetch stopped until redirect
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [63:0] MEM_BYTES   = 64'h58
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fault
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      inst_q, inst_d;
  logic [63:0]      inst_pc_q, inst_pc_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             pc_bad;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
      inst_q    <= 32'h0;
      inst_pc_q <= 64'h0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  assign pc_bad = (pc_q >= MEM_BYTES) || (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    fault_d   = fault_q;

    // A redirect overrides everything. A handshake completing in the same
    // cycle is still taken by decode; only later work is discarded.
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      cnt_d   = '0;
      valid_d = 1'b0;
      fault_d = 1'b0;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (pc_bad) begin
            fault_d = 1'b1;
            cnt_d   = '0;
            state_d = HALT;
          end else if (cnt_q == CNT_LAST) begin
            inst_d    = imem_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 64'd4;
            valid_d   = 1'b1;
            cnt_d     = '0;
            state_d   = VALID;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        VALID: begin
          if (inst_ready) begin
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
        HALT: begin
          valid_d = 1'b0;
        end
        default: begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with WAIT_CYCLES=2 and a
// 22-word combinational instruction image.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        Reset_L;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;

  int errors = 0;
  int checks = 0;
  int accept_cnt = 0;
  logic [63:0] last_acc_pc = 64'h0;

  logic [31:0] rom [0:31];

  instruction_fetch_unit #(
    .RESET_PC   (64'h0),
    .WAIT_CYCLES(2),
    .MEM_BYTES  (64'h58)
  ) dut (
    .CLK           (CLK),
    .Reset_L       (Reset_L),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fault         (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign imem_data = (imem_addr < 64'h58 && imem_addr[1:0] == 2'b00) ?
                     rom[imem_addr[6:2]] : 32'hDEAD_BEEF;

  always @(posedge CLK) begin
    if (Reset_L && inst_valid && inst_ready) begin
      accept_cnt  <= accept_cnt + 1;
      last_acc_pc <= inst_pc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (inst_valid === 1'b1) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset_L = 1'b0;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    tick();
    tick();
    checks++;
    if (imem_addr !== 64'h0 || inst_valid !== 1'b0 || fault !== 1'b0 ||
        inst !== 32'h0 || inst_pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: addr=%h valid=%b fault=%b inst=%h pc=%h, want 0/0/0/0/0",
               imem_addr, inst_valid, fault, inst, inst_pc);
    end
    Reset_L = 1'b1;
  endtask

  task automatic test_stream();
    bit ok;
    int cyc;
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 2 || inst !== 32'hF840_03E9 || inst_pc !== 64'h0 || imem_addr !== 64'h4) begin
      errors++;
      $display("FAIL first_fetch: ok=%b cyc=%0d inst=%h pc=%h addr=%h, want 1/2/f84003e9/0/4",
               ok, cyc, inst, inst_pc, imem_addr);
    end
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 3 || inst !== 32'hF840_83EA || inst_pc !== 64'h4) begin
      errors++;
      $display("FAIL second_fetch: ok=%b cyc=%0d inst=%h pc=%h, want 1/3/f84083ea/4",
               ok, cyc, inst, inst_pc);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int cyc;
    tick();
    inst_ready = 1'b0;
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 2 || inst !== 32'hF841_03EB || inst_pc !== 64'h8 || imem_addr !== 64'hC) begin
      errors++;
      $display("FAIL stall_arrive: ok=%b cyc=%0d inst=%h pc=%h addr=%h, want 1/2/f84103eb/8/c",
               ok, cyc, inst, inst_pc, imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'hF841_03EB || inst_pc !== 64'h8 || imem_addr !== 64'hC) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b inst=%h pc=%h addr=%h, want 1/f84103eb/8/c",
                 i, inst_valid, inst, inst_pc, imem_addr);
      end
    end
    inst_ready = 1'b1;
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 3 || inst !== 32'hF841_83EC || inst_pc !== 64'hC) begin
      errors++;
      $display("FAIL stall_release: ok=%b cyc=%0d inst=%h pc=%h, want 1/3/f84183ec/c",
               ok, cyc, inst, inst_pc);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    int cyc;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h34;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 64'h34 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_load: addr=%h valid=%b, want 34/0", imem_addr, inst_valid);
    end
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 2 || inst !== 32'hD29B_DE01 || inst_pc !== 64'h34) begin
      errors++;
      $display("FAIL redirect_fetch: ok=%b cyc=%0d inst=%h pc=%h, want 1/2/d29bde01/34",
               ok, cyc, inst, inst_pc);
    end
  endtask

  task automatic test_sequential_fault();
    bit ok;
    int cyc;
    logic [63:0] exp_pc;
    for (exp_pc = 64'h38; exp_pc <= 64'h54; exp_pc += 64'h4) begin
      wait_valid(10, ok, cyc);
      checks++;
      if (!ok || inst_pc !== exp_pc || inst !== rom[exp_pc[6:2]]) begin
        errors++;
        $display("FAIL seq_fetch: ok=%b pc=%h inst=%h, want pc=%h inst=%h",
                 ok, inst_pc, inst, exp_pc, rom[exp_pc[6:2]]);
      end
    end
    checks++;
    if (inst !== 32'hF842_83EA) begin
      errors++;
      $display("FAIL last_word: inst=%h, want f84283ea", inst);
    end
    tick();
    tick();
    checks++;
    if (fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 64'h58) begin
      errors++;
      $display("FAIL range_fault: fault=%b valid=%b addr=%h, want 1/0/58",
               fault, inst_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 64'h58) begin
        errors++;
        $display("FAIL halt_hold[%0d]: fault=%b valid=%b addr=%h, want 1/0/58",
                 i, fault, inst_valid, imem_addr);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h0;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL fault_clear: fault=%b addr=%h, want 0/0", fault, imem_addr);
    end
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 2 || inst !== 32'hF840_03E9 || inst_pc !== 64'h0) begin
      errors++;
      $display("FAIL refetch_zero: ok=%b cyc=%0d inst=%h pc=%h, want 1/2/f84003e9/0",
               ok, cyc, inst, inst_pc);
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc = 64'h36;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 64'h36) begin
      errors++;
      $display("FAIL misalign_load: fault=%b valid=%b addr=%h, want 0/0/36",
               fault, inst_valid, imem_addr);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_fault: fault=%b valid=%b, want 1/0", fault, inst_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 64'h36) begin
        errors++;
        $display("FAIL misalign_hold[%0d]: valid=%b fault=%b addr=%h, want 0/1/36",
                 i, inst_valid, fault, imem_addr);
      end
    end
  endtask

  task automatic test_redirect_handshake();
    bit ok;
    int cyc;
    int acc_before;
    redirect_valid = 1'b1;
    redirect_pc = 64'h28;
    tick();
    redirect_valid = 1'b0;
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || inst !== 32'h17FF_FFFD || inst_pc !== 64'h28) begin
      errors++;
      $display("FAIL pre_handshake: ok=%b inst=%h pc=%h, want 1/17fffffd/28", ok, inst, inst_pc);
    end
    acc_before = accept_cnt;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1C;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (accept_cnt != acc_before + 1 || last_acc_pc !== 64'h28 || inst_valid !== 1'b0 ||
        imem_addr !== 64'h1C) begin
      errors++;
      $display("FAIL coincident_accept: accepts=%0d pc=%h valid=%b addr=%h, want %0d/28/0/1c",
               accept_cnt - acc_before, last_acc_pc, inst_valid, imem_addr, 1);
    end
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 2 || inst !== 32'h8B02_0020 || inst_pc !== 64'h1C ||
        accept_cnt != acc_before + 1) begin
      errors++;
      $display("FAIL after_coincident: ok=%b cyc=%0d inst=%h pc=%h accepts=%0d, want 1/2/8b020020/1c/1",
               ok, cyc, inst, inst_pc, accept_cnt - acc_before);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int cyc;
    tick();
    tick();
    #2;
    Reset_L = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 64'h0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
        inst_pc !== 64'h0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: addr=%h valid=%b inst=%h pc=%h fault=%b, want all 0",
               imem_addr, inst_valid, inst, inst_pc, fault);
    end
    tick();
    Reset_L = 1'b1;
    wait_valid(10, ok, cyc);
    checks++;
    if (!ok || cyc != 2 || inst !== 32'hF840_03E9 || inst_pc !== 64'h0) begin
      errors++;
      $display("FAIL post_reset_fetch: ok=%b cyc=%0d inst=%h pc=%h, want 1/2/f84003e9/0",
               ok, cyc, inst, inst_pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 | 32'(i * 4);
    rom[0]  = 32'hF840_03E9;
    rom[1]  = 32'hF840_83EA;
    rom[2]  = 32'hF841_03EB;
    rom[3]  = 32'hF841_83EC;
    rom[7]  = 32'h8B02_0020;
    rom[10] = 32'h17FF_FFFD;
    rom[13] = 32'hD29B_DE01;
    rom[21] = 32'hF842_83EA;

    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_sequential_fault();
    test_misaligned();
    test_redirect_handshake();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
